// File: rtl/pattern_pkg.sv
// pattern_pkg: state type and default constants shared by the serializer and the pattern detector
package pattern_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DEF_WIDTH = 8;
  localparam logic DEF_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/word_serializer_if.sv
// word_serializer_if: word-in / bit-out handshake bundle of the serializer
interface word_serializer_if
  import pattern_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             msb_first;
  logic             bit_out;
  logic             bit_valid;
  logic             word_done;
  logic             busy;
  modport master (output in_data, in_valid, msb_first, input in_ready, bit_out, bit_valid, word_done, busy);
  modport slave (input in_data, in_valid, msb_first, output in_ready, bit_out, bit_valid, word_done, busy);
endinterface

// File: rtl/word_serializer.sv
// word_serializer: parallel word to serial bit stream with a one-word hold buffer and no gap between words
module word_serializer
  import pattern_pkg::*;
#(
  parameter int   WIDTH      = DEF_WIDTH,
  parameter logic IDLE_LEVEL = DEF_IDLE_LEVEL
) (
  input logic clk,
  input logic reset,
  word_serializer_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d, hold_q, hold_d, ld_word;
  logic             sh_msb_q, sh_msb_d, hold_msb_q, hold_msb_d, ld_msb;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bit_out_q, bit_out_d, bit_valid_q, bit_valid_d, word_done_q, word_done_d;
  logic             in_ready_q, in_ready_d, busy_q, busy_d;
  logic             accept, last, take_hold, take_in, to_hold, advance, load;
  // next state: outputs are derived from the post-edge shifter so they can be registered without adding latency
  always_comb begin
    accept      = bus.in_valid & in_ready_q;
    last        = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
    take_hold   = last & hold_full_q;
    take_in     = accept & ((state_q == IDLE) | last);
    to_hold     = accept & (state_q == SHIFT) & ~last;
    advance     = (state_q == SHIFT) & ~last;
    load        = take_in | take_hold;
    ld_word     = take_hold ? hold_q : bus.in_data;
    ld_msb      = take_hold ? hold_msb_q : bus.msb_first;
    hold_full_d = to_hold | (hold_full_q & ~take_hold);
    hold_d      = to_hold ? bus.in_data : hold_q;
    hold_msb_d  = to_hold ? bus.msb_first : hold_msb_q;
    state_d     = (load | advance) ? SHIFT : IDLE;
    sh_d        = load ? ld_word : advance ? (sh_msb_q ? sh_q << 1 : sh_q >> 1) : sh_q;
    sh_msb_d    = load ? ld_msb : sh_msb_q;
    cnt_d       = load ? '0 : advance ? cnt_q + 1'b1 : '0;
    bit_valid_d = state_d == SHIFT;
    bit_out_d   = bit_valid_d ? (sh_msb_d ? sh_d[WIDTH-1] : sh_d[0]) : IDLE_LEVEL;
    word_done_d = bit_valid_d && (cnt_d == CW'(WIDTH - 1));
    in_ready_d  = ~hold_full_d;
    busy_d      = bit_valid_d | hold_full_d;
  end
  // state and registered outputs; reset drops both the word in flight and the held word
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      sh_msb_q    <= 1'b0;
      hold_q      <= '0;
      hold_msb_q  <= 1'b0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      bit_out_q   <= IDLE_LEVEL;
      bit_valid_q <= 1'b0;
      word_done_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      sh_msb_q    <= sh_msb_d;
      hold_q      <= hold_d;
      hold_msb_q  <= hold_msb_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      word_done_q <= word_done_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end
  assign bus.bit_out   = bit_out_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.word_done = word_done_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: word-queue model compared every cycle plus literal bit-stream expectations
module tb_word_serializer;
  import pattern_pkg::*;
  localparam int W = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  word_serializer_if #(.WIDTH(W)) bus();
  word_serializer #(.WIDTH(W), .IDLE_LEVEL(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [W-1:0] mw[$];
  logic mo[$];
  int pos = 0;
  logic acc_last = 1'b0;
  bit started = 1'b0;
  bit rec[$];
  int rec_cyc[$];
  int done_idx[$];
  int rises = 0;
  int ready_low = 0;
  logic prev_v = 1'b0;
  logic prev_b = 1'b1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  initial forever begin
    @(posedge clk);
    cyc++;
    started = 1'b1;
    if (reset) begin
      mw.delete();
      mo.delete();
      pos = 0;
      acc_last = 1'b0;
    end else begin
      acc_last = bus.in_valid && (mw.size() < 2);
      if (mw.size() > 0) begin
        pos++;
        if (pos == W) begin
          mw.delete(0);
          mo.delete(0);
          pos = 0;
        end
      end
      if (acc_last) begin
        mw.push_back(bus.in_data);
        mo.push_back(bus.msb_first);
      end
    end
  end
  initial forever begin
    logic eb;
    logic act;
    @(negedge clk);
    if (started) begin
      act = mw.size() > 0;
      eb = act ? mw[0][mo[0] ? W - 1 - pos : pos] : 1'b1;
      chk("bit_valid", bus.bit_valid, act);
      chk("bit_out", bus.bit_out, eb);
      chk("word_done", bus.word_done, act && pos == W - 1);
      chk("in_ready", bus.in_ready, mw.size() < 2);
      chk("busy", bus.busy, act);
      if (bus.bit_valid) begin
        rec.push_back(bus.bit_out);
        rec_cyc.push_back(cyc);
        if (bus.word_done) done_idx.push_back(rec.size() - 1);
        if (prev_v && !prev_b && bus.bit_out) rises++;
      end
      if (bus.in_valid && !bus.in_ready) ready_low++;
      prev_v = bus.bit_valid;
      prev_b = bus.bit_out;
    end
  end
  task automatic send(input logic [W-1:0] d, input logic m, output int waited);
    bus.in_data = d;
    bus.msb_first = m;
    bus.in_valid = 1'b1;
    waited = 0;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (!acc_last && waited < 64);
    if (!acc_last) chk("accept_timeout", 32'd0, 32'd1);
  endtask
  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic clear_rec();
    rec.delete();
    rec_cyc.delete();
    done_idx.delete();
  endtask
  task automatic check_rec(input string nm, input logic [31:0] exp, input int n);
    chk({nm, "_len"}, rec.size(), n);
    for (int i = 0; i < n && i < rec.size(); i++) chk({nm, "_bit"}, rec[i], exp[n-1-i]);
  endtask
  initial begin
    int w;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.msb_first = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_bit_out", bus.bit_out, 1);
    chk("rst_busy", bus.busy, 0);
    reset = 1'b0;
    clear_rec();
    send(8'hA5, 1'b1, w);
    chk("first_accept_wait", w, 1);
    idle(12);
    check_rec("a5_msb", 32'hA5, 8);
    chk("a5_done_cnt", done_idx.size(), 1);
    if (done_idx.size() > 0) chk("a5_done_pos", done_idx[0], 7);
    if (rec_cyc.size() == 8) chk("a5_contig", rec_cyc[7] - rec_cyc[0], 7);
    clear_rec();
    send(8'h01, 1'b0, w);
    idle(12);
    check_rec("01_lsb", 32'h80, 8);
    clear_rec();
    send(8'h0F, 1'b1, w);
    send(8'hF0, 1'b1, w);
    idle(20);
    check_rec("b2b", 32'h0FF0, 16);
    if (rec_cyc.size() == 16) chk("b2b_contig", rec_cyc[15] - rec_cyc[0], 15);
    chk("b2b_done_cnt", done_idx.size(), 2);
    if (done_idx.size() == 2) chk("b2b_done2", done_idx[1], 15);
    clear_rec();
    ready_low = 0;
    send(8'h12, 1'b1, w);
    send(8'h34, 1'b0, w);
    send(8'h56, 1'b1, w);
    chk("third_wait", w > 1, 1);
    idle(30);
    check_rec("three", 32'h122C56, 24);
    chk("ready_held_low", ready_low > 0, 1);
    clear_rec();
    send(8'hFF, 1'b1, w);
    send(8'h00, 1'b1, w);
    bus.in_valid = 1'b0;
    w = 0;
    while (rec.size() < 5 && w < 64) begin
      @(negedge clk);
      w++;
    end
    chk("rst_mid_reach", rec.size(), 5);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", bus.bit_valid, 0);
    chk("rst_mid_out", bus.bit_out, 1);
    chk("rst_mid_ready", bus.in_ready, 1);
    idle(20);
    chk("rst_mid_len", rec.size(), 5);
    for (int i = 0; i < rec.size(); i++) chk("rst_mid_ones", rec[i], 1);
    clear_rec();
    rises = 0;
    send(8'hAA, 1'b1, w);
    idle(12);
    check_rec("aa", 32'hAA, 8);
    chk("aa_rises", rises, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
